// File: rtl/if_id_skid_stage_pkg.sv
// rtl/if_id_skid_stage_pkg.sv - shared CPU pipeline types and default widths
package if_id_skid_stage_pkg;

    localparam int PC_W_DEF    = 64;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/if_id_skid_stage_pipe_data_reg.sv
// rtl/if_id_skid_stage_pipe_data_reg.sv - enabled payload register with synchronous reset
module pipe_data_reg #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - two-entry IF/ID skid buffer with registered in_ready
module if_id_skid_stage
    import if_id_skid_stage_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    localparam int DW = PC_W + INSTR_W;

    skid_state_e   state;
    skid_state_e   state_next;
    logic          main_en;
    logic          skid_en;
    logic          main_from_skid;
    logic          in_xfer;
    logic          out_xfer;
    logic [DW-1:0] in_data;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    // Both handshake flags decode only the state register, so no ready path
    // runs combinationally from decode back to fetch.
    assign in_ready  = (state != SKID_TWO);
    assign out_valid = (state == SKID_ONE) || (state == SKID_TWO);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign in_data   = {in_pc, in_instr};
    assign main_d    = main_from_skid ? skid_q : in_data;
    assign out_pc    = main_q[DW-1:INSTR_W];
    assign out_instr = main_q[INSTR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_next = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (in_xfer) begin
                        main_en    = 1'b1;
                        state_next = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        skid_en    = 1'b1;
                        state_next = SKID_TWO;
                    end else if (out_xfer) begin
                        state_next = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    if (out_xfer) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_next     = SKID_ONE;
                    end
                end
                default: state_next = SKID_EMPTY;
            endcase
        end
    end

    pipe_data_reg #(.W(DW)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.W(DW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - scoreboard bench for the IF/ID skid stage
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;
    logic [95:0] sb[$];

    always #5 clk = ~clk;

    if_id_skid_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic present(input logic [63:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    // Samples handshakes mid-cycle, then advances past the next rising edge.
    task automatic cycle(output logic ifire, output logic ofire, output logic [95:0] obs);
        @(negedge clk);
        ifire = in_valid && in_ready;
        ofire = out_valid && out_ready;
        obs   = {out_pc, out_instr};
        if (ifire && !flush && !reset) sb.push_back({in_pc, in_instr});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic i, o;
        logic [95:0] d;
        reset = 1'b1;
        cycle(i, o, d);
        cycle(i, o, d);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    endtask

    task automatic test_pass_through();
        logic i, o;
        logic [95:0] d, exp;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) present(64'(4 * k)); else in_valid = 1'b0;
            cycle(i, o, d);
            if (k < 3) begin
                checks++; if (i !== 1'b1) begin errors++; $display("FAIL pass_in_fire k=%0d got %b want 1", k, i); end
            end
            if (k > 0) begin
                checks++;
                if (o !== 1'b1 || sb.size() == 0) begin
                    errors++; $display("FAIL pass_out_fire k=%0d got %b want 1", k, o);
                end else begin
                    exp = sb.pop_front();
                    checks++; if (d !== exp) begin errors++; $display("FAIL pass_data k=%0d got %h want %h", k, d, exp); end
                end
            end
        end
        checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin errors++; $display("FAIL pass_drain out_valid %b left %0d want 0 0", out_valid, sb.size()); end
    endtask

    task automatic test_back_pressure();
        logic i, o;
        logic [95:0] d, exp;
        int outs = 0;
        out_ready = 1'b0;
        present(64'h100); cycle(i, o, d);
        present(64'h104); cycle(i, o, d);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        present(64'h108);
        for (int k = 0; k < 2; k++) begin
            cycle(i, o, d);
            checks++; if (i !== 1'b0) begin errors++; $display("FAIL bp_held_off got %b want 0", i); end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            cycle(i, o, d);
            if (i) in_valid = 1'b0;
            if (o) begin
                exp = sb.pop_front();
                outs++;
                checks++; if (d !== exp) begin errors++; $display("FAIL bp_order got %h want %h", d, exp); end
            end
        end
        checks++; if (outs != 3 || in_valid !== 1'b0) begin errors++; $display("FAIL bp_count got %0d want 3", outs); end
    endtask

    task automatic test_flush();
        logic i, o;
        logic [95:0] d;
        out_ready = 1'b0;
        present(64'h200); cycle(i, o, d);
        present(64'h204); cycle(i, o, d);
        present(64'h300); flush = 1'b1;
        cycle(i, o, d);
        flush = 1'b0; in_valid = 1'b0; sb.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_two_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_two_in_ready got %b want 1", in_ready); end
        // Flush from EMPTY while an input would otherwise be accepted.
        present(64'h310); flush = 1'b1; out_ready = 1'b1;
        cycle(i, o, d);
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(i, o, d);
            checks++; if (o !== 1'b0) begin errors++; $display("FAIL flush_leak got out pc %h want none", d[95:32]); end
        end
    endtask

    task automatic test_simultaneous();
        logic i, o;
        logic [95:0] d, exp;
        out_ready = 1'b0;
        present(64'h400); cycle(i, o, d);
        present(64'h404); out_ready = 1'b1;
        cycle(i, o, d);
        in_valid = 1'b0;
        checks++; if (!(i && o)) begin errors++; $display("FAIL simul_fire got in %b out %b want 1 1", i, o); end
        exp = sb.pop_front();
        checks++; if (d !== exp) begin errors++; $display("FAIL simul_first got %h want %h", d, exp); end
        checks++; if (out_pc !== 64'h404 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL simul_one got pc %h valid %b ready %b want 404 1 1", out_pc, out_valid, in_ready);
        end
        cycle(i, o, d);
        exp = sb.pop_front();
        checks++; if (d !== exp || o !== 1'b1) begin errors++; $display("FAIL simul_drain got %h want %h", d, exp); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic i, o;
        logic [95:0] d, exp;
        logic seen = 1'b0;
        out_ready = 1'b0;
        present(64'h480); cycle(i, o, d);
        present(64'h484); cycle(i, o, d);
        in_valid = 1'b0; reset = 1'b1;
        cycle(i, o, d);
        reset = 1'b0; sb.delete();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL rmid_out_pc got %h want 0", out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        present(64'h500); out_ready = 1'b1;
        for (int k = 0; k < 5 && !seen; k++) begin
            cycle(i, o, d);
            if (i) in_valid = 1'b0;
            if (o) begin
                seen = 1'b1;
                exp = sb.pop_front();
                checks++; if (d !== exp) begin errors++; $display("FAIL rmid_first got %h want %h", d, exp); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_timeout got none want 500"); end
    endtask

    task automatic test_random();
        logic i, o;
        logic [95:0] d, exp;
        logic [63:0] next_pc = 64'h1000;
        int outs = 0;
        for (int k = 0; k < 400; k++) begin
            if (k >= 300) begin
                if (!in_valid && sb.size() == 0 && !out_valid) break;
                out_ready = 1'b1;
            end else begin
                if (!in_valid && $urandom_range(0, 3) != 0) begin
                    present(next_pc);
                    next_pc += 64'd4;
                end
                out_ready = $urandom_range(0, 1);
            end
            cycle(i, o, d);
            if (i) in_valid = 1'b0;
            if (o) begin
                outs++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got %h want none", d);
                end else begin
                    exp = sb.pop_front();
                    if (d !== exp) begin errors++; $display("FAIL rand_order got %h want %h", d, exp); end
                end
            end
        end
        checks++; if (sb.size() != 0 || outs == 0) begin errors++; $display("FAIL rand_drain left %0d outs %0d want 0 >0", sb.size(), outs); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 Parameters (name, default, meaning):
- PC_W, 64, program-counter width.
- INSTR_W, 32, instruction word width.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discards all held entries (branch mispredict/redirect).
- in_valid  input  1  fetch stage presents an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_pc  input  PC_W  PC of the presented instruction.
- in_instr  input  INSTR_W  presented instruction word.
- out_valid  output  1  decode-side entry available.
- out_ready  input  1  decode stage accepts the entry this cycle.
- out_pc  output  PC_W  PC of the head entry.
- out_instr  output  INSTR_W  instruction word of the head entry.

Function
REQ-003 Transfer rules:
- An input transfer occurs on a rising edge when in_valid and in_ready are both 1.
- An output transfer occurs on a rising edge when out_valid and out_ready are both 1.
REQ-004 Storage is two entries, a main entry and a skid entry. States:
- EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
REQ-005 in_ready is a registered signal: 1 exactly when the state is not TWO. It never depends combinationally on out_ready.
REQ-006 out_valid is 1 exactly when the state is ONE or TWO. out_pc/out_instr always reflect the main entry.
REQ-007 Transitions when flush=0:
- EMPTY, input transfer -> ONE, in_* captured into main.
- ONE, input transfer only -> TWO, in_* captured into skid.
- ONE, output transfer only -> EMPTY.
- ONE, input and output transfer together -> ONE, main replaced by in_*.
- TWO, output transfer -> ONE, skid moved into main.
- No transfer -> state and data held.
REQ-008 Latency: an entry accepted into EMPTY appears on out_* the next cycle. There is no combinational path from in_* to out_*.
REQ-009 Ordering is strict FIFO; no entry is duplicated or lost except by flush or reset.
REQ-010 Flush: flush=1 forces the state to EMPTY on that edge. It takes priority over any simultaneous input or output transfer; the input offered that cycle is discarded.
REQ-011 Output data are don't-care while out_valid=0. The payload registers need not be cleared on flush.
REQ-012 Behaviour is defined only for in_valid held with stable data until accepted. The block does not police upstream protocol violations.

Reset
REQ-013 reset=1 at a rising edge forces, regardless of flush or handshakes:
- state EMPTY;
- out_valid=0;
- in_ready=1 on the following cycle;
- out_pc=0, out_instr=0.
REQ-014 Reset asserted mid-operation discards all held entries. The first input transfer after reset deasserts is the next one presented on out_*.

Structure
REQ-015 The skid-state enum (EMPTY/ONE/TWO) and the PC_W/INSTR_W defaults live in the shared CPU pipeline package.
REQ-016 Payload storage uses one sub-module, pipe_data_reg: a PC_W+INSTR_W-wide enabled D register with synchronous reset. It is instantiated twice, once for main and once for skid. Control logic is a single FSM in if_id_skid_stage.

Verification
REQ-017 Pass-through: out_ready=1; present PC 0x0, 0x4, 0x8 on consecutive cycles -> same PCs on out_pc on consecutive cycles, one cycle later, out_valid=1 throughout.
REQ-018 Back-pressure: out_ready=0; present 0x100 then 0x104 -> in_ready=0 after the second transfer and 0x108 held off; raise out_ready -> outputs 0x100, 0x104, 0x108 in order.
REQ-019 Flush in TWO state: hold 0x200 and 0x204; assert flush with in_valid=1, PC 0x300 -> next cycle out_valid=0, in_ready=1, and 0x300 never emitted.
REQ-020 Simultaneous transfer in ONE: main=0x400; in_valid=1 (0x404) and out_ready=1 on the same edge -> next cycle out_pc=0x404, state ONE.
REQ-021 Reset mid-operation: state TWO, then reset=1 for one cycle -> out_valid=0, out_pc=0, in_ready=1; the next input 0x500 appears first on out_pc.
